// File: rtl/hex_display_pkg.sv
// Shared definitions for the hex display sequencer: source geometry, mode encodings
// and the round-robin "next captured source" search.
package hex_display_pkg;

  localparam int unsigned NumSrc = 4;
  localparam int unsigned SrcW   = 32;
  localparam int unsigned SelW   = 2;

  typedef enum logic [1:0] {
    ModeAuto   = 2'b00,
    ModeManual = 2'b01,
    ModeFreeze = 2'b10
  } mode_e;

  typedef struct packed {
    logic            found;
    logic [SelW-1:0] idx;
  } pick_t;

  // Nearest captured source after sel, scanning sel+1, sel+2, sel+3 (wrapping).
  function automatic pick_t next_src(logic [SelW-1:0] sel, logic [NumSrc-1:0] captured);
    pick_t           pick;
    logic [SelW-1:0] j;
    pick = '{found: 1'b0, idx: sel};
    for (int i = NumSrc - 1; i >= 1; i--) begin
      j = sel + SelW'(i);
      if (captured[j]) pick = '{found: 1'b1, idx: j};
    end
    return pick;
  endfunction

endpackage

// File: rtl/hex_dwell_timer.sv
// Dwell counter 0..Dwell-1 with a terminal pulse; clear restarts the count from 0 in
// the same cycle and suppresses the pulse, disable holds the count at 0.
module hex_dwell_timer #(
  parameter int unsigned Dwell = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_terminal
);

  localparam logic [31:0] Last = 32'(Dwell - 1);

  logic [31:0] cnt_q, cnt_d, cnt_cur;

  always_comb begin
    cnt_cur    = i_clear ? '0 : cnt_q;
    o_terminal = i_enable && !i_clear && (cnt_cur == Last);
    if (!i_enable || o_terminal) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_cur + 32'd1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/hex_display_sequencer.sv
// Captures four 32-bit source words and steps the displayed source automatically,
// by key press, or not at all, skipping sources that have never been captured.
module hex_display_sequencer
  import hex_display_pkg::*;
#(
  parameter int unsigned DWELL = 50000000
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [NumSrc*SrcW-1:0] i_src_data,
  input  logic [NumSrc-1:0]      i_src_valid,
  input  logic [1:0]             i_mode,
  input  logic                   i_next,
  output logic [SrcW-1:0]        o_value,
  output logic [SelW-1:0]        o_sel,
  output logic                   o_blank,
  output logic [NumSrc-1:0]      o_fresh,
  output logic                   o_tick
);

  logic [NumSrc-1:0][SrcW-1:0] cap_q, cap_d;
  logic [NumSrc-1:0]           captured_q, captured_d;
  logic [NumSrc-1:0]           fresh_q, fresh_d;
  logic [SelW-1:0]             sel_q, sel_d;
  logic [1:0]                  mode_q;
  logic                        next_q, armed_q, tick_q, tick_d;
  logic                        mode_chg, is_auto, is_manual, key_rise, dwell_term, advance;
  pick_t                       pick;

  assign mode_chg  = (i_mode != mode_q);
  assign is_auto   = (i_mode == ModeAuto);
  assign is_manual = (i_mode == ModeManual);

  hex_dwell_timer #(
    .Dwell(DWELL)
  ) u_dwell (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clear   (mode_chg),
    .i_enable  (is_auto),
    .o_terminal(dwell_term)
  );

  always_comb begin
    pick       = next_src(sel_q, captured_q);
    // armed_q blocks a key that was already held when reset released
    key_rise   = i_next && !next_q && armed_q;
    advance    = !mode_chg && (dwell_term || (is_manual && key_rise));
    sel_d      = (advance && pick.found) ? pick.idx : sel_q;
    tick_d     = (sel_d != sel_q);
    cap_d      = cap_q;
    captured_d = captured_q | i_src_valid;
    fresh_d    = '0;
    for (int k = 0; k < NumSrc; k++) begin
      if (i_src_valid[k]) cap_d[k] = i_src_data[SrcW*k +: SrcW];
      fresh_d[k] = (fresh_q[k] || i_src_valid[k]) && (sel_d != SelW'(k));
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cap_q      <= '0;
      captured_q <= '0;
      fresh_q    <= '0;
      sel_q      <= '0;
      mode_q     <= ModeAuto;
      next_q     <= 1'b0;
      armed_q    <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      cap_q      <= cap_d;
      captured_q <= captured_d;
      fresh_q    <= fresh_d;
      sel_q      <= sel_d;
      mode_q     <= i_mode;
      next_q     <= i_next;
      armed_q    <= armed_q || !i_next;
      tick_q     <= tick_d;
    end
  end

  assign o_value = cap_q[sel_q];
  assign o_sel   = sel_q;
  assign o_blank = !captured_q[sel_q];
  assign o_fresh = fresh_q;
  assign o_tick  = tick_q;

endmodule

// File: tb/tb_hex_display_sequencer.sv
// Directed scenarios plus a randomized run, checked against a cycle-level behavioural model.
module tb_hex_display_sequencer;

  localparam int unsigned DW = 4;

  logic         i_clk = 1'b0;
  logic         i_rst;
  logic [127:0] i_src_data;
  logic [3:0]   i_src_valid;
  logic [1:0]   i_mode;
  logic         i_next;
  logic [31:0]  o_value;
  logic [1:0]   o_sel;
  logic         o_blank;
  logic [3:0]   o_fresh;
  logic         o_tick;

  int n_cmp = 0;
  int n_bad = 0;
  int ticks = 0;

  // Reference model state
  logic [31:0] m_cap[4];
  bit          m_got[4];
  bit          m_fresh[4];
  int          m_sel, m_cnt;
  logic [1:0]  m_mprev;
  bit          m_nprev, m_armed, m_tick;

  always #5 i_clk = ~i_clk;

  hex_display_sequencer #(
    .DWELL(DW)
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_src_data (i_src_data),
    .i_src_valid(i_src_valid),
    .i_mode     (i_mode),
    .i_next     (i_next),
    .o_value    (o_value),
    .o_sel      (o_sel),
    .o_blank    (o_blank),
    .o_fresh    (o_fresh),
    .o_tick     (o_tick)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_cap[k]   = 32'h0;
      m_got[k]   = 1'b0;
      m_fresh[k] = 1'b0;
    end
    m_sel   = 0;
    m_cnt   = 0;
    m_mprev = 2'd0;
    m_nprev = 1'b0;
    m_armed = 1'b0;
    m_tick  = 1'b0;
  endtask

  task automatic model_edge();
    bit chg, adv, found;
    int c, nsel, j;
    chg = (i_mode != m_mprev);
    adv = 1'b0;
    if (i_mode == 2'd0) begin
      c = chg ? 0 : m_cnt;
      if (!chg && c == DW - 1) begin
        adv   = 1'b1;
        m_cnt = 0;
      end else begin
        m_cnt = c + 1;
      end
    end else begin
      m_cnt = 0;
    end
    if (!chg && i_mode == 2'd1 && i_next && !m_nprev && m_armed) adv = 1'b1;
    if (!i_next) m_armed = 1'b1;
    m_nprev = i_next;
    m_mprev = i_mode;
    nsel  = m_sel;
    found = 1'b0;
    if (adv) begin
      for (int off = 1; off <= 3; off++) begin
        j = (m_sel + off) % 4;
        if (!found && m_got[j]) begin
          nsel  = j;
          found = 1'b1;
        end
      end
    end
    m_tick = (nsel != m_sel);
    for (int k = 0; k < 4; k++) begin
      if (i_src_valid[k]) begin
        m_cap[k] = i_src_data[32*k +: 32];
        m_got[k] = 1'b1;
      end
      m_fresh[k] = (m_fresh[k] || i_src_valid[k]) && (k != nsel);
    end
    m_sel = nsel;
  endtask

  task automatic check_model();
    logic [3:0] f;
    for (int k = 0; k < 4; k++) f[k] = m_fresh[k];
    chk("m_sel", 32'(o_sel), 32'(m_sel));
    chk("m_value", o_value, m_cap[m_sel]);
    chk("m_blank", 32'(o_blank), 32'(!m_got[m_sel]));
    chk("m_fresh", 32'(o_fresh), 32'(f));
    chk("m_tick", 32'(o_tick), 32'(m_tick));
  endtask

  task automatic step();
    @(posedge i_clk);
    model_edge();
    #1;
    check_model();
    if (o_tick) ticks++;
  endtask

  // Asynchronous reset in mid-cycle; outputs must clear before any clock edge.
  task automatic do_reset();
    #3;
    i_rst       = 1'b1;
    i_mode      = 2'd0;
    i_src_valid = 4'b0;
    #1;
    chk("rst_sel", 32'(o_sel), 32'd0);
    chk("rst_value", o_value, 32'h0);
    chk("rst_blank", 32'(o_blank), 32'd1);
    chk("rst_fresh", 32'(o_fresh), 32'd0);
    chk("rst_tick", 32'(o_tick), 32'd0);
    model_reset();
    #2;
    i_rst = 1'b0;
  endtask

  initial begin
    i_rst       = 1'b1;
    i_src_data  = '0;
    i_src_valid = 4'b0;
    i_mode      = 2'd0;
    i_next      = 1'b0;

    // Single captured source in AUTO: 0 -> 2 at first terminal count, then hold
    do_reset();
    i_src_data[95:64] = 32'hDEADBEEF;
    i_src_valid       = 4'b0100;
    step();
    i_src_valid = 4'b0;
    chk("s1_val_unsel", o_value, 32'h0);
    chk("s1_fresh", 32'(o_fresh), 32'b0100);
    step();
    step();
    chk("s1_sel_before", 32'(o_sel), 32'd0);
    step();
    chk("s1_sel", 32'(o_sel), 32'd2);
    chk("s1_val", o_value, 32'hDEADBEEF);
    chk("s1_tick", 32'(o_tick), 32'd1);
    ticks = 0;
    repeat (8) step();
    chk("s1_hold_ticks", 32'(ticks), 32'd0);
    chk("s1_hold_sel", 32'(o_sel), 32'd2);

    // Three sources captured together, source 2 skipped in rotation
    do_reset();
    i_src_data  = {32'h33333333, 32'h0, 32'h22222222, 32'h11111111};
    i_src_valid = 4'b1011;
    step();
    i_src_valid = 4'b0;
    chk("s2_fresh", 32'(o_fresh), 32'b1010);
    chk("s2_val0", o_value, 32'h11111111);
    ticks = 0;
    repeat (3) step();
    chk("s2_sel1", 32'(o_sel), 32'd1);
    chk("s2_val1", o_value, 32'h22222222);
    repeat (4) step();
    chk("s2_sel3", 32'(o_sel), 32'd3);
    repeat (4) step();
    chk("s2_sel0", 32'(o_sel), 32'd0);
    chk("s2_ticks", 32'(ticks), 32'd3);
    repeat (8) step();
    chk("s6_sel3", 32'(o_sel), 32'd3);
    i_src_valid = 4'b0001;
    step();
    i_src_valid = 4'b0;
    chk("s6_fresh_pre", 32'(o_fresh), 32'b0001);
    do_reset();

    // MANUAL: key held across reset gives nothing; each fresh press one advance
    i_next = 1'b1;
    do_reset();
    i_src_valid = 4'b0011;
    i_mode      = 2'd1;
    step();
    i_src_valid = 4'b0;
    ticks       = 0;
    repeat (10) step();
    chk("s3_held_ticks", 32'(ticks), 32'd0);
    i_next = 1'b0;
    repeat (2) step();
    i_next = 1'b1;
    ticks  = 0;
    repeat (10) step();
    chk("s3_press_ticks", 32'(ticks), 32'd1);
    chk("s3_sel1", 32'(o_sel), 32'd1);
    i_next = 1'b0;
    step();
    i_next = 1'b1;
    step();
    chk("s3_sel0", 32'(o_sel), 32'd0);

    // Fresh flags
    i_next = 1'b0;
    do_reset();
    i_mode      = 2'd1;
    i_src_data  = {32'h0, 32'h0, 32'hA5A50001, 32'h0};
    i_src_valid = 4'b0010;
    step();
    i_src_valid = 4'b0;
    chk("s4_fresh_set", 32'(o_fresh), 32'b0010);
    chk("s4_blank", 32'(o_blank), 32'd1);
    i_next = 1'b1;
    step();
    chk("s4_sel", 32'(o_sel), 32'd1);
    chk("s4_fresh_clr", 32'(o_fresh), 32'd0);
    i_next      = 1'b0;
    i_src_data  = {32'h0, 32'h0, 32'h5A5A0002, 32'h0};
    i_src_valid = 4'b0010;
    step();
    i_src_valid = 4'b0;
    chk("s4_fresh_sel", 32'(o_fresh), 32'd0);
    chk("s4_val_new", o_value, 32'h5A5A0002);

    // FREEZE mid-dwell, then a full dwell after returning to AUTO
    do_reset();
    i_src_data  = {32'h0, 32'h0, 32'hBBBB0001, 32'hAAAA0000};
    i_src_valid = 4'b0011;
    step();
    i_src_valid = 4'b0;
    step();
    i_mode = 2'd2;
    ticks  = 0;
    repeat (5) step();
    chk("s5_freeze_ticks", 32'(ticks), 32'd0);
    i_mode = 2'd0;
    repeat (3) step();
    chk("s5_sel_wait", 32'(o_sel), 32'd0);
    step();
    chk("s5_sel_adv", 32'(o_sel), 32'd1);
    chk("s5_tick", 32'(o_tick), 32'd1);

    // Randomized run
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      if ($urandom_range(0, 15) == 0) i_mode = 2'($urandom_range(0, 3));
      i_src_valid = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
      i_src_data  = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 3) == 0) i_next = ~i_next;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hex_display_sequencer.md
HEX_DISPLAY_SEQUENCER -- requirements
Module: hex_display_sequencer

Interface
REQ-001 Parameter DWELL, default 50000000, AUTO-mode dwell time per source in i_clk cycles; legal range 2..2^32-1.
REQ-002 i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 i_rst  input  1  reset, asynchronous, active-high.
REQ-004 i_src_data  input  128  four 32-bit source words; source k occupies bits [32k+31:32k].
REQ-005 i_src_valid  input  4  per-source capture strobe; bit k high captures source k word.
REQ-006 i_mode  input  2  00 AUTO, 01 MANUAL, 10 FREEZE, 11 treated as FREEZE.
REQ-007 i_next  input  1  synchronized, debounced step key level; active-high.
REQ-008 o_value  output  32  word currently shown; drives the eight-digit hex decoder.
REQ-009 o_sel  output  2  index of the currently shown source.
REQ-010 o_blank  output  1  high when the shown source has never been captured since reset.
REQ-011 o_fresh  output  4  bit k high: source k captured new data since it was last shown.
REQ-012 o_tick  output  1  one-cycle pulse on every cycle in which o_sel changes.

Function
REQ-013 The block SHALL hold one 32-bit capture register and one captured flag per source; i_src_valid[k] loads i_src_data word k and sets captured[k] at the next edge.
REQ-014 o_value SHALL be the capture register selected by o_sel (registered sel, combinational mux); new data SHALL appear on o_value one cycle after its strobe when that source is selected.
REQ-015 An advance event SHALL set o_sel to the first j in order sel+1, sel+2, sel+3 (mod 4) with captured[j] set, using flags registered before the edge; if none, o_sel SHALL be unchanged and o_tick SHALL stay low.
REQ-016 AUTO: a 32-bit dwell counter SHALL count 0..DWELL-1; on the cycle it equals DWELL-1 an advance event SHALL occur and the counter SHALL return to 0.
REQ-017 MANUAL: a registered copy of i_next SHALL detect rising edges; each rising edge SHALL produce exactly one advance event; holding i_next high SHALL produce no further events.
REQ-018 FREEZE: no advance events; dwell counter held at 0; captures continue.
REQ-019 Any change of i_mode SHALL clear the dwell counter in that cycle; no advance event occurs in a mode-change cycle.
REQ-020 fresh[k] SHALL set on capture of k when k is not o_sel after the edge; fresh[k] SHALL clear on the edge where o_sel becomes k; capture of k coinciding with selection of k SHALL leave fresh[k] low.
REQ-021 o_blank SHALL equal NOT captured[o_sel]; o_value SHALL read 32'h0 for never-captured sources.
REQ-022 Simultaneous strobes on several sources SHALL all be captured in the same cycle.

Reset
REQ-023 On i_rst high, asynchronously: o_sel=0, all capture registers 0, captured=0, o_fresh=0, dwell counter 0, i_next history 0, o_tick=0; hence o_value=0 and o_blank=1.
REQ-024 Reset asserted mid-dwell or mid-key-press SHALL discard all progress; after release, a key held high SHALL NOT produce an advance until released and pressed again.

Structure
REQ-025 Mode encodings (AUTO, MANUAL, FREEZE) and source count 4 SHALL be defined in the shared package hex_display_pkg.
REQ-026 The dwell counter with terminal pulse SHALL be one sub-module, hex_dwell_timer (inputs clear and enable, output terminal pulse).
REQ-027 The hex-to-segment decoding SHALL stay outside this block; the instantiating top-level connects o_value to the decoder.

Verification (DWELL=4)
REQ-028 Reset, then strobe source 2 with 32'hDEADBEEF, AUTO -> o_value=DEADBEEF one cycle after strobe only once o_sel=2; o_sel 0->2 at first terminal count, then stays at 2 with no o_tick.
REQ-029 Capture sources 0,1,3 with 0x11111111/0x22222222/0x33333333, AUTO -> o_sel sequence 0,1,3,0 every 4 cycles, o_tick one pulse per change, source 2 skipped.
REQ-030 MANUAL, sources 0,1 captured, i_next held high 10 cycles -> exactly one advance 0->1; release and press again -> 1->0.
REQ-031 o_sel=0, strobe source 1 -> o_fresh=4'b0010; advance to 1 -> o_fresh=0; strobe 1 while selected -> o_fresh stays 0.
REQ-032 AUTO at counter=2, switch to FREEZE for 5 cycles then back to AUTO -> no advance during FREEZE; next advance exactly 4 cycles after return.
REQ-033 Assert i_rst asynchronously mid-dwell with o_sel=3 -> o_sel=0, o_value=0, o_blank=1, o_fresh=0 immediately, without a clock edge.
